data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (core load/store)
//  and port 1 (debug/test readout). Arbitrates round-robin, range-checks addresses and
//  returns registered read data. Also runs a CLEAR sequencer that zero-fills the memory
//  on request, blocking both requesters until it finishes. Sits between core and memory.
// PARAMETERS
//  MEM_DEPTH  100  number of 32-bit words; legal addresses are 0..MEM_DEPTH-1
//  AW         32   requester address width
// PORTS
//  CLK          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-low reset
//  rN_req       in   1   N=0,1: access request; held until rN_gnt
//  rN_we        in   1   1 = write, 0 = read; valid while rN_req
//  rN_addr      in   AW  word address
//  rN_wdata     in   32  write data
//  rN_gnt       out  1   access accepted this cycle (combinational)
//  rN_rvalid    out  1   one-cycle pulse: response for the previous grant
//  rN_rdata     out  32  read data, valid with rN_rvalid (0 for writes/errors)
//  rN_err       out  1   with rN_rvalid: address was out of range
//  clr_start    in   1   pulse: begin zero-fill
//  clr_busy     out  1   high while in CLEAR
//  clr_done     out  1   one-cycle pulse on the first cycle after CLEAR
//  mem_A        out  AW  memory address
//  mem_WD       out  32  memory write data
//  mem_WE       out  1   memory write enable
//  mem_RD       in   32  memory read data (combinational from mem_A)
// BEHAVIOUR
//  Reset (reset=0 at an edge): state=ARB, last=1 (port 0 wins first tie), clear count=0.
//   All outputs are 0. A CLEAR in progress aborts and clr_done is not pulsed.
//  FSM ARB:
//   - clr_start=1: go to CLEAR next cycle. No grant this cycle, even with req high.
//   - Else, one request: grant it. Both requests: grant port != last; last := granted.
//   - Grant cycle: mem_A=addr. mem_WE=we & in-range. mem_WD=wdata.
//     At the edge, a write commits.
//   - Next cycle: rN_rvalid=1.
//     * Read: rN_rdata = mem_RD sampled at the grant edge.
//     * Write: rN_rdata = 0.
//     * Out of range (addr >= MEM_DEPTH): rN_err=1, rdata=0, no write.
//   - A requester may hold req for back-to-back grants. With both requesting, grants
//     alternate every cycle.
//   - No grant: mem_A=0, mem_WD=0, mem_WE=0.
//  FSM CLEAR:
//   - clr_busy=1, both gnt=0, clr_start ignored.
//   - Each cycle: mem_A=cnt, mem_WD=0, mem_WE=1; cnt increments.
//   - After the cnt=MEM_DEPTH-1 write: cnt := 0, state := ARB.
//   - clr_done=1 on that first ARB cycle (registered). Arbitration resumes that cycle.
//   - Total: MEM_DEPTH write cycles.
//  Response pulses from a grant in the last ARB cycle before CLEAR are still delivered.
//  The req/we/addr/wdata of a non-granted port are ignored. No other state is kept.
// TESTING
//  1. Reset, r0 write addr 5 = 0xDEADBEEF, then r0 read 5
//     -> gnt same cycle; next cycle rvalid=1, rdata=0xDEADBEEF, err=0.
//  2. r0 and r1 both hold req for 4 cycles after reset
//     -> grants 0,1,0,1; each rvalid follows its grant by 1 cycle.
//  3. r1 read addr 100 (MEM_DEPTH=100)
//     -> gnt=1, mem_WE=0; next cycle r1_rvalid=1, r1_err=1, r1_rdata=0.
//  4. Fill addr 0..99, pulse clr_start with r0_req high
//     -> no gnt; 100 cycles clr_busy=1 and mem_WE=1 (mem_A 0..99);
//     clr_done pulse; read 42 -> 0.
//  5. reset=0 at cycle 30 of CLEAR -> next cycle clr_busy=0, no clr_done;
//     arbiter grants r0 normally.
//  6. clr_start re-pulsed during CLEAR -> ignored; exactly one clr_done after 100 cycles.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter_if
//  Purpose  : Bundles the two requester handshakes, the CLEAR control and the
//             single-port data memory bus of data_mem_arbiter.
//  Ports    : rN_req/we/addr/wdata   requester -> arbiter (N = 0,1)
//             rN_gnt/rvalid/rdata/err arbiter -> requester
//             clr_start -> arbiter, clr_busy/clr_done <- arbiter
//             mem_A/mem_WD/mem_WE -> memory, mem_RD <- memory
//  Modports : slave  = arbiter side, master = requester/memory side
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [31:0]   r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [31:0]   r0_rdata;
    logic          r0_err;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [31:0]   r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [31:0]   r1_rdata;
    logic          r1_err;

    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;

    logic [AW-1:0] mem_A;
    logic [31:0]   mem_WD;
    logic          mem_WE;
    logic [31:0]   mem_RD;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_A, mem_WD, mem_WE,
        input  mem_RD
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_A, mem_WD, mem_WE,
        output mem_RD
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port data memory between
//             the core (port 0) and debug readout (port 1). Range-checks
//             addresses, returns registered read data one cycle after the
//             grant, and runs a zero-fill CLEAR sequencer that locks out both
//             requesters until the whole memory has been written.
//  Ports    : CLK    clock, rising edge
//             reset  synchronous, active-low
//             bus    data_mem_arbiter_if.slave (requesters, CLEAR, memory)
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int MEM_DEPTH = 100,
    parameter int AW        = 32
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    data_mem_arbiter_if.slave  bus
);
    localparam int CW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [0:0] S_ARB   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [CW-1:0] c_LAST  = CW'(MEM_DEPTH - 1);
    localparam logic [AW-1:0] c_DEPTH = AW'(MEM_DEPTH);

    logic [0:0]    state_q, state_d;
    logic          last_q, last_d;      // port granted at the last contended grant
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          w_arb, w_in0, w_in1, w_g0, w_g1;

    // Grants are suppressed while reset is low so nothing reaches memory then.
    assign w_arb = reset && (state_q == S_ARB) && !bus.clr_start;
    assign w_in0 = bus.r0_addr < c_DEPTH;
    assign w_in1 = bus.r1_addr < c_DEPTH;
    assign w_g0  = w_arb && bus.r0_req && (!bus.r1_req || last_q);
    assign w_g1  = w_arb && bus.r1_req && (!bus.r0_req || !last_q);

    assign bus.r0_gnt    = w_g0;
    assign bus.r1_gnt    = w_g1;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
    assign bus.r0_err    = err0_q;
    assign bus.r1_err    = err1_q;
    assign bus.clr_busy  = (state_q == S_CLEAR);
    assign bus.clr_done  = done_q;

    // Memory bus mux: sequencer, then granted port, else idle zeros.
    always_comb begin
        bus.mem_A  = '0;
        bus.mem_WD = '0;
        bus.mem_WE = 1'b0;
        if (reset && (state_q == S_CLEAR)) begin
            bus.mem_A  = AW'(cnt_q);
            bus.mem_WE = 1'b1;
        end else if (w_g0) begin
            bus.mem_A  = bus.r0_addr;
            bus.mem_WD = bus.r0_wdata;
            bus.mem_WE = bus.r0_we && w_in0;
        end else if (w_g1) begin
            bus.mem_A  = bus.r1_addr;
            bus.mem_WD = bus.r1_wdata;
            bus.mem_WE = bus.r1_we && w_in1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_ARB: begin
                if (bus.clr_start) begin
                    state_d = S_CLEAR;
                end
                // Only a contended grant moves the round-robin pointer.
                if (w_g0 && bus.r1_req) begin
                    last_d = 1'b0;
                end
                if (w_g1 && bus.r0_req) begin
                    last_d = 1'b1;
                end
            end
            default: begin
                if (cnt_q == c_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        rvalid0_d = w_g0;
        rvalid1_d = w_g1;
        err0_d    = w_g0 && !w_in0;
        err1_d    = w_g1 && !w_in1;
        rdata0_d  = (w_g0 && !bus.r0_we && w_in0) ? bus.mem_RD : 32'h0;
        rdata1_d  = (w_g1 && !bus.r1_we && w_in1) ? bus.mem_RD : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q   <= S_ARB;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Directed and randomized bench for data_mem_arbiter with a
//             transaction-level reference model and a behavioural memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;
    localparam int MEM_DEPTH = 100;
    localparam int AW        = 32;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    data_mem_arbiter_if #(.AW(AW)) bus ();

    data_mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural single-port memory seen by the DUT.
    logic [31:0] mem_arr [0:127];
    assign bus.mem_RD = (bus.mem_A < 32'(MEM_DEPTH)) ? mem_arr[bus.mem_A[6:0]] : 32'h0;
    always @(posedge CLK) begin
        if (bus.mem_WE && (bus.mem_A < 32'(MEM_DEPTH)))
            mem_arr[bus.mem_A[6:0]] <= bus.mem_WD;
    end

    // Reference model state.
    logic [31:0] ref_mem [MEM_DEPTH];
    bit          m_clearing;
    int          m_cnt;
    int          m_last;
    bit          e_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations from the most recent cycle.
    bit obs_g0, obs_g1, obs_busy, obs_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
        m_clearing = 0; m_cnt = 0; m_last = 1; e_done = 0;
        check("rst_rvalid0", bus.r0_rvalid, 0);
        check("rst_rvalid1", bus.r1_rvalid, 0);
        check("rst_rdata0",  bus.r0_rdata,  0);
        check("rst_err1",    bus.r1_err,    0);
        check("rst_busy",    bus.clr_busy,  0);
        check("rst_done",    bus.clr_done,  0);
    endtask

    // One clock cycle: inputs must already be driven.
    task automatic cycle();
        int          gp;
        logic [31:0] a, wd, ea, ewd, erd;
        bit          we, ewe, inr;
        bit          erv0, erv1, eerr0, eerr1;
        logic [31:0] erd0, erd1;
        #1;
        gp = -1; ea = 0; ewd = 0; ewe = 0;
        erv0 = 0; erv1 = 0; eerr0 = 0; eerr1 = 0; erd0 = 0; erd1 = 0;
        if (m_clearing) begin
            ea = m_cnt; ewe = 1;
        end else if (!bus.clr_start) begin
            if (bus.r0_req && bus.r1_req) gp = (m_last == 0) ? 1 : 0;
            else if (bus.r0_req)          gp = 0;
            else if (bus.r1_req)          gp = 1;
        end
        if (gp >= 0) begin
            a   = (gp == 1) ? bus.r1_addr  : bus.r0_addr;
            wd  = (gp == 1) ? bus.r1_wdata : bus.r0_wdata;
            we  = (gp == 1) ? bus.r1_we    : bus.r0_we;
            inr = (a < MEM_DEPTH);
            ea  = a; ewd = wd; ewe = we && inr;
            erd = (!we && inr) ? ref_mem[a] : 32'h0;
            if (gp == 0) begin erv0 = 1; erd0 = erd; eerr0 = !inr; end
            else         begin erv1 = 1; erd1 = erd; eerr1 = !inr; end
        end
        obs_g0 = bus.r0_gnt; obs_g1 = bus.r1_gnt; obs_busy = bus.clr_busy;
        check("gnt0",   bus.r0_gnt,   (gp == 0));
        check("gnt1",   bus.r1_gnt,   (gp == 1));
        check("mem_WE", bus.mem_WE,   ewe);
        check("mem_A",  bus.mem_A,    ea);
        check("mem_WD", bus.mem_WD,   ewd);
        check("busy",   bus.clr_busy, m_clearing);

        // Model update at the edge.
        if (ewe) ref_mem[ea] = ewd;
        if (gp >= 0 && bus.r0_req && bus.r1_req) m_last = gp;
        e_done = 0;
        if (m_clearing) begin
            if (m_cnt == MEM_DEPTH - 1) begin
                m_clearing = 0; m_cnt = 0; e_done = 1;
            end else begin
                m_cnt++;
            end
        end else if (bus.clr_start) begin
            m_clearing = 1;
        end

        @(posedge CLK);
        #1;
        obs_done = bus.clr_done;
        check("rvalid0", bus.r0_rvalid, erv0);
        check("rvalid1", bus.r1_rvalid, erv1);
        check("rdata0",  bus.r0_rdata,  erd0);
        check("rdata1",  bus.r1_rdata,  erd1);
        check("err0",    bus.r0_err,    eerr0);
        check("err1",    bus.r1_err,    eerr1);
        check("done",    bus.clr_done,  e_done);
    endtask

    task automatic idle();
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 0; bus.r1_wdata = 0;
        bus.clr_start = 0;
    endtask

    task automatic drive0(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    endtask

    task automatic drive1(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    endtask

    task automatic fill();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            drive0(1, 1, i, 32'hA500_0000 + i);
            cycle();
        end
        idle();
    endtask

    // Pulse clr_start and run until the clear finishes plus extra cycles.
    task automatic run_clear(input int pulse_at, input int extra,
                             output int busy_cnt, output int done_cnt);
        busy_cnt = 0; done_cnt = 0;
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        for (int k = 0; k < MEM_DEPTH + extra; k++) begin
            bus.clr_start = (k == pulse_at);
            cycle();
            if (obs_busy) busy_cnt++;
            if (obs_done) done_cnt++;
        end
        bus.clr_start = 0;
    endtask

    initial begin
        int  bc, dc;
        bit  got;
        bit          pend0, pend1;
        logic [31:0] a;

        idle();
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
        do_reset();
        // Bring the behavioural memory to a known all-zero state.
        run_clear(-1, 2, bc, dc);

        // 1: write then read back on port 0.
        drive0(1, 1, 5, 32'hDEADBEEF);
        cycle();
        check("t1_wr_gnt", obs_g0, 1);
        drive0(1, 0, 5, 0);
        cycle();
        check("t1_rd_gnt", obs_g0, 1);
        check("t1_rdata", bus.r0_rdata, 32'hDEADBEEF);
        check("t1_err", bus.r0_err, 0);
        idle();

        // 2: both ports requesting after reset alternate 0,1,0,1.
        do_reset();
        drive0(1, 0, 1, 0);
        drive1(1, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_gnt0", obs_g0, (i % 2 == 0));
            check("t2_gnt1", obs_g1, (i % 2 == 1));
        end
        idle();

        // 3: out-of-range read on port 1.
        drive1(1, 0, MEM_DEPTH, 0);
        cycle();
        check("t3_gnt", obs_g1, 1);
        check("t3_err", bus.r1_err, 1);
        check("t3_rdata", bus.r1_rdata, 0);
        idle();

        // 4: fill, then clear with port 0 requesting, then read 42.
        fill();
        check("t4_prefill", ref_mem[42], 32'hA500_002A);
        drive0(1, 0, 42, 0);
        bus.clr_start = 1;
        cycle();
        check("t4_no_gnt", obs_g0, 0);
        bus.clr_start = 0;
        bc = 0; dc = 0; got = 0;
        for (int k = 0; k < MEM_DEPTH + 10 && !got; k++) begin
            cycle();
            if (obs_busy) bc++;
            if (obs_done) dc++;
            got = obs_g0;
        end
        check("t4_granted", got, 1);
        check("t4_busy_cycles", bc, MEM_DEPTH);
        check("t4_done_pulses", dc, 1);
        check("t4_rd42", bus.r0_rdata, 0);
        idle();

        // 5: reset in the middle of CLEAR aborts it silently.
        fill();
        bus.clr_start = 1;
        cycle();
        bus.clr_start = 0;
        for (int k = 0; k < 30; k++) cycle();
        drive0(1, 0, 50, 0);
        do_reset();
        check("t5_busy", bus.clr_busy, 0);
        cycle();
        check("t5_gnt", obs_g0, 1);
        check("t5_rd50", bus.r0_rdata, 32'hA500_0032);
        check("t5_no_done", obs_done, 0);
        idle();

        // 6: clr_start during CLEAR is ignored.
        run_clear(50, 15, bc, dc);
        check("t6_busy_cycles", bc, MEM_DEPTH);
        check("t6_done_pulses", dc, 1);

        // Randomized traffic with held requests and occasional clears.
        pend0 = 0; pend1 = 0;
        for (int n = 0; n < 700; n++) begin
            if (!pend0) begin
                a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 109));
                drive0($urandom_range(0, 2) != 0, $urandom_range(0, 1), a, $urandom);
            end
            if (!pend1) begin
                a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 109));
                drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1), a, $urandom);
            end
            bus.clr_start = ($urandom_range(0, 149) == 0);
            cycle();
            pend0 = bus.r0_req && !obs_g0;
            pend1 = bus.r1_req && !obs_g1;
        end
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
